issue_scheduler: RTL and testbench
==================================

# issue_scheduler

Instruction-queue and issue-gating controller between instruction fetch and the issue stage. Buffers fetched instructions in a circular FIFO and releases the head to issue only when the ROB and the correct target station have space. Load/store heads need the LSB; all other heads need the RS. Flushes on rollback and keeps per-cause stall counters for performance debug.

## Interface
- `IQ_LOG`, default 4: log2 of queue depth; DEPTH = 2^IQ_LOG = 16 entries.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `rdy`  in  1  global ready; when low, all state holds and `inst_valid` = 0.
- `rollback`  in  1  mispredict/exception flush from ROB commit.
- `if_valid`  in  1  fetch delivers an instruction this cycle.
- `if_inst`  in  32  fetched instruction word.
- `if_pc`  in  32  PC of `if_inst`.
- `iq_full`  out  1  backpressure to fetch.
- `rob_full`  in  1  ROB has no free entry this cycle.
- `rs_full`  in  1  RS has no free entry this cycle.
- `lsb_full`  in  1  LSB has no free entry this cycle.
- `inst_valid`  out  1  head instruction is issued this cycle.
- `inst_to_issue`  out  32  head instruction word.
- `pc_to_issue`  out  32  head PC.
- `stall_rob_cnt`  out  32  cycles the head was blocked by ROB.
- `stall_rs_cnt`  out  32  cycles the head was blocked by RS only.
- `stall_lsb_cnt`  out  32  cycles the head was blocked by LSB only.

## Operation
- State: entry arrays `inst_q[DEPTH]` and `pc_q[DEPTH]`; `head` and `tail` (IQ_LOG bits, natural wrap); `count` (IQ_LOG+1 bits); three stall counters.
- Head class: `is_mem` = head opcode[6:0] ∈ {0000011 load, 0100011 store}.
- Issue condition: `inst_valid` = rdy & ~rollback & (count≠0) & ~rob_full & (is_mem ? ~lsb_full : ~rs_full). Combinational.
- Pop occurs on the edge where `inst_valid`=1: head+1, count−1.
- Push occurs on an edge with rdy & ~rollback & if_valid & (count<DEPTH): write at tail, tail+1, count+1.
- Push and pop on the same edge leave count unchanged. This is legal even when count=DEPTH−1 or count=1.
- `iq_full` = (count ≥ DEPTH−1). The one-slot margin absorbs a fetch already in flight when `iq_full` rises. A push with count=DEPTH and no pop is dropped; the bench flags it as an error.
- Rollback (rdy=1): on that edge head=tail=count=0; any push in that cycle is discarded; stall counters are not cleared. `inst_valid`=0 during the rollback cycle.
- Stall accounting is evaluated only when rdy & ~rollback & count≠0 & ~inst_valid:
  - ROB full → `stall_rob_cnt`+1.
  - else if is_mem → `stall_lsb_cnt`+1.
  - else → `stall_rs_cnt`+1.
  - Counters saturate at 2^32−1.
- `inst_to_issue`/`pc_to_issue` = 0 when count=0; otherwise the head entry.

## Timing
- Reset: head=tail=count=0, all stall counters 0, `inst_valid`=0, `iq_full`=0, `inst_to_issue`=0, `pc_to_issue`=0. Array contents are don't-care.
- Reset overrides rollback, push and pop on the same edge.
- Latency: an instruction pushed on edge N is visible at head from cycle N+1. The earliest `inst_valid` is cycle N+1. There is no same-cycle bypass.
- Throughput: one issue per cycle while the queue is non-empty and targets are not full.
- Full flags are sampled in the same cycle as `inst_valid`. Consumers allocate on the same edge as the pop.
- rdy low: no push, no pop, no counter update, outputs still reflect head contents, `inst_valid`=0.

## Structure
- Add to `config.v`: `` `IQ_LOG ``, `` `OPC_LOAD `` (7'b0000011), `` `OPC_STORE `` (7'b0100011).
- One sub-module is natural: `iq_fifo` holds the storage arrays, head/tail/count, push/pop/flush and the empty/full flags.
- `issue_scheduler` wraps `iq_fifo` and adds the issue condition, the class decode and the stall counters.

## Test plan
- Reset, push ADDI (0x00100093, pc 0x0) at edge 1 → `inst_valid`=1 in cycle 2 with pc 0x0; queue empty after edge 2.
- Push 16 instructions with all full flags high → `iq_full` rises when count=15; the 16th push is accepted with count=16; with stalls held, `stall_rob_cnt` increments each cycle.
- Head LW (0x0000A103) with lsb_full=1, rs_full=0 → `inst_valid`=0 and `stall_lsb_cnt` increments; release lsb_full → issues next cycle. Same test with head ADD and rs_full → `stall_rs_cnt`.
- Queue count 5, rollback together with if_valid → count 0 next cycle, pushed instruction absent, `inst_valid`=0 during the rollback cycle.
- Continuous push+pop for 40 cycles → head/tail wrap past 15; PCs issue in order 0x0,0x4,…,0x9C; count constant.
- rdy low for 3 cycles mid-stream with if_valid=1 → no state change; resumes identically once rdy returns.

Source files
------------

// File: rtl/issue_scheduler_pkg.sv
// Shared constants and helpers for the instruction-queue issue scheduler.
// Opcode classes decide which reservation target (RS or LSB) gates issue.
package issue_scheduler_pkg;

  localparam int         IQ_LOG_DEF = 4;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  typedef enum logic [1:0] {
    STALL_NONE,
    STALL_ROB,
    STALL_RS,
    STALL_LSB
  } stall_cause_e;

  function automatic logic is_mem_op(input logic [31:0] inst);
    return (inst[6:0] == OPC_LOAD) || (inst[6:0] == OPC_STORE);
  endfunction

endpackage

// File: rtl/issue_scheduler_if.sv
// Fetch, issue-target and performance-counter signals of the issue scheduler.
// master drives fetch/flags (fetch + backend side), slave is the scheduler.
interface issue_scheduler_if;
  logic        rdy;
  logic        rollback;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        iq_full;
  logic        rob_full;
  logic        rs_full;
  logic        lsb_full;
  logic        inst_valid;
  logic [31:0] inst_to_issue;
  logic [31:0] pc_to_issue;
  logic [31:0] stall_rob_cnt;
  logic [31:0] stall_rs_cnt;
  logic [31:0] stall_lsb_cnt;

  modport master (
    output rdy, rollback, if_valid, if_inst, if_pc, rob_full, rs_full, lsb_full,
    input  iq_full, inst_valid, inst_to_issue, pc_to_issue,
           stall_rob_cnt, stall_rs_cnt, stall_lsb_cnt
  );

  modport slave (
    input  rdy, rollback, if_valid, if_inst, if_pc, rob_full, rs_full, lsb_full,
    output iq_full, inst_valid, inst_to_issue, pc_to_issue,
           stall_rob_cnt, stall_rs_cnt, stall_lsb_cnt
  );
endinterface

// File: rtl/issue_scheduler_iq_fifo.sv
// Circular instruction/PC queue with push, pop and flush.
// Almost-full asserts one entry early so an in-flight fetch still fits.
module iq_fifo #(
  parameter int IQ_LOG = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_push,
  input  logic        i_pop,
  input  logic        i_flush,
  input  logic [31:0] i_inst,
  input  logic [31:0] i_pc,
  output logic [31:0] o_head_inst,
  output logic [31:0] o_head_pc,
  output logic        o_empty,
  output logic        o_almost_full
);
  localparam int              DEPTH   = 1 << IQ_LOG;
  localparam logic [IQ_LOG:0] DEPTH_C = (IQ_LOG+1)'(DEPTH);

  logic [31:0]       r_inst_q [DEPTH];
  logic [31:0]       r_pc_q   [DEPTH];
  logic [IQ_LOG-1:0] r_head;
  logic [IQ_LOG-1:0] r_tail;
  logic [IQ_LOG:0]   r_count;
  logic              w_push_ok;
  logic              w_pop_ok;

  assign o_empty       = (r_count == '0);
  assign o_almost_full = (r_count >= DEPTH_C - 1'b1);
  assign w_push_ok     = i_push & ~i_flush & (r_count < DEPTH_C);
  assign w_pop_ok      = i_pop & ~i_flush & ~o_empty;
  assign o_head_inst   = o_empty ? 32'd0 : r_inst_q[r_head];
  assign o_head_pc     = o_empty ? 32'd0 : r_pc_q[r_head];

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_pop_ok)  r_head <= r_head + 1'b1;
      if (w_push_ok) r_tail <= r_tail + 1'b1;
      r_count <= r_count + (IQ_LOG+1)'(w_push_ok) - (IQ_LOG+1)'(w_pop_ok);
    end
  end

  // Storage needs no reset; the head mux hides stale entries while empty.
  always_ff @(posedge clk) begin
    if (!rst && w_push_ok) begin
      r_inst_q[r_tail] <= i_inst;
      r_pc_q[r_tail]   <= i_pc;
    end
  end

endmodule

// File: rtl/issue_scheduler.sv
// Issue gating on top of the instruction queue: class decode, ROB/RS/LSB
// space check, rollback flush and saturating per-cause stall counters.
module issue_scheduler
  import issue_scheduler_pkg::*;
#(
  parameter int IQ_LOG = IQ_LOG_DEF
) (
  input logic               clk,
  input logic               rst,
  issue_scheduler_if.slave  bus
);
  logic [31:0]  w_head_inst;
  logic [31:0]  w_head_pc;
  logic         w_empty;
  logic         w_almost_full;
  logic         w_active;
  logic         w_is_mem;
  logic         w_issue;
  stall_cause_e w_cause;
  logic [31:0]  r_stall_rob;
  logic [31:0]  r_stall_rs;
  logic [31:0]  r_stall_lsb;

  iq_fifo #(.IQ_LOG(IQ_LOG)) u_iq_fifo (
    .clk           (clk),
    .rst           (rst),
    .i_push        (w_active & bus.if_valid),
    .i_pop         (w_issue),
    .i_flush       (bus.rdy & bus.rollback),
    .i_inst        (bus.if_inst),
    .i_pc          (bus.if_pc),
    .o_head_inst   (w_head_inst),
    .o_head_pc     (w_head_pc),
    .o_empty       (w_empty),
    .o_almost_full (w_almost_full)
  );

  assign w_active = bus.rdy & ~bus.rollback;
  assign w_is_mem = is_mem_op(w_head_inst);
  assign w_issue  = w_active & ~w_empty & ~bus.rob_full &
                    (w_is_mem ? ~bus.lsb_full : ~bus.rs_full);

  always_comb begin
    w_cause = STALL_NONE;
    if (w_active && !w_empty && !w_issue) begin
      if (bus.rob_full)  w_cause = STALL_ROB;
      else if (w_is_mem) w_cause = STALL_LSB;
      else               w_cause = STALL_RS;
    end
  end

  // Counters survive rollback so stall totals span a whole run.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_rob <= '0;
      r_stall_rs  <= '0;
      r_stall_lsb <= '0;
    end else begin
      unique case (w_cause)
        STALL_ROB: if (r_stall_rob != '1) r_stall_rob <= r_stall_rob + 32'd1;
        STALL_RS:  if (r_stall_rs  != '1) r_stall_rs  <= r_stall_rs  + 32'd1;
        STALL_LSB: if (r_stall_lsb != '1) r_stall_lsb <= r_stall_lsb + 32'd1;
        default: ;
      endcase
    end
  end

  assign bus.iq_full       = w_almost_full;
  assign bus.inst_valid    = w_issue;
  assign bus.inst_to_issue = w_head_inst;
  assign bus.pc_to_issue   = w_head_pc;
  assign bus.stall_rob_cnt = r_stall_rob;
  assign bus.stall_rs_cnt  = r_stall_rs;
  assign bus.stall_lsb_cnt = r_stall_lsb;

endmodule

// File: tb/tb_issue_scheduler.sv
// Self-checking bench: a queue model holds expected head entries and stall
// counts; every cycle the DUT outputs are compared against it.
module tb_issue_scheduler;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  localparam logic [31:0] I_ADDI = 32'h00100093;
  localparam logic [31:0] I_LW   = 32'h0000A103;
  localparam logic [31:0] I_SW   = 32'h0020A023;
  localparam logic [31:0] I_ADD  = 32'h002080B3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  issue_scheduler_if bus ();

  issue_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  ent_t        sb[$];
  logic [31:0] m_rob = 0;
  logic [31:0] m_rs  = 0;
  logic [31:0] m_lsb = 0;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic mem_op(input logic [31:0] inst);
    return (inst[6:0] == 7'h03) || (inst[6:0] == 7'h23);
  endfunction

  // Drive one cycle, compare at the falling edge, then advance the model.
  task automatic cyc(input logic rdy_i, input logic rb, input logic ifv,
                     input logic [31:0] inst, input logic [31:0] pc,
                     input logic robf, input logic rsf, input logic lsbf);
    logic        e_valid;
    logic [31:0] e_inst, e_pc;
    ent_t        popped;
    bus.rdy = rdy_i; bus.rollback = rb; bus.if_valid = ifv;
    bus.if_inst = inst; bus.if_pc = pc;
    bus.rob_full = robf; bus.rs_full = rsf; bus.lsb_full = lsbf;
    @(negedge clk);
    e_inst  = (sb.size() != 0) ? sb[0].inst : 32'd0;
    e_pc    = (sb.size() != 0) ? sb[0].pc   : 32'd0;
    e_valid = rdy_i && !rb && (sb.size() != 0) && !robf &&
              (mem_op(e_inst) ? !lsbf : !rsf);
    chk("inst_valid", {31'd0, bus.inst_valid}, {31'd0, e_valid});
    chk("iq_full", {31'd0, bus.iq_full}, {31'd0, sb.size() >= 15});
    chk("stall_rob_cnt", bus.stall_rob_cnt, m_rob);
    chk("stall_rs_cnt", bus.stall_rs_cnt, m_rs);
    chk("stall_lsb_cnt", bus.stall_lsb_cnt, m_lsb);
    if (e_valid && bus.inst_valid) begin
      popped = sb.pop_front();
      chk("issued_inst", bus.inst_to_issue, popped.inst);
      chk("issued_pc", bus.pc_to_issue, popped.pc);
    end else begin
      chk("head_inst", bus.inst_to_issue, e_inst);
      chk("head_pc", bus.pc_to_issue, e_pc);
      if (e_valid) void'(sb.pop_front());
    end
    if (rst) begin
      sb.delete(); m_rob = 0; m_rs = 0; m_lsb = 0;
    end else if (rdy_i) begin
      if (rb) sb.delete();
      else begin
        if ((sb.size() != 0 || e_valid) && !e_valid) begin
          if (robf)                m_rob = m_rob + 1;
          else if (mem_op(e_inst)) m_lsb = m_lsb + 1;
          else                     m_rs  = m_rs + 1;
        end
        // e_valid already removed the head; capacity is judged pre-edge.
        if (ifv) begin
          if (sb.size() + (e_valid ? 1 : 0) < 16) sb.push_back('{inst, pc});
          else chk("dropped_push", 32'd1, 32'd0);
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n, input logic robf, input logic rsf, input logic lsbf);
    for (int k = 0; k < n; k++) cyc(1, 0, 0, 32'd0, 32'd0, robf, rsf, lsbf);
  endtask

  initial begin
    logic [31:0] r;
    logic [6:0]  opc;
    logic [31:0] pc_run;
    bus.rdy = 0; bus.rollback = 0; bus.if_valid = 0; bus.if_inst = 0; bus.if_pc = 0;
    bus.rob_full = 0; bus.rs_full = 0; bus.lsb_full = 0;
    @(posedge clk); #1;
    // Reset overrides a simultaneous push.
    cyc(1, 0, 1, I_ADDI, 32'h44, 0, 0, 0);
    rst = 0;
    idle(1, 0, 0, 0);

    // Single ADDI: issues the cycle after its push, then queue is empty.
    cyc(1, 0, 1, I_ADDI, 32'h0, 0, 0, 0);
    idle(2, 0, 0, 0);

    // Fill all 16 slots with every target full, hold, then drain.
    for (int i = 0; i < 16; i++) cyc(1, 0, 1, I_ADDI + (i << 20), 32'h100 + 4*i, 1, 1, 1);
    idle(3, 1, 1, 1);
    idle(17, 0, 0, 0);

    // Class-specific stalls: load/store on LSB, ALU on RS.
    cyc(1, 0, 1, I_LW, 32'h200, 0, 0, 1);
    idle(3, 0, 0, 1);
    idle(1, 0, 0, 0);
    cyc(1, 0, 1, I_ADD, 32'h204, 0, 1, 0);
    idle(3, 0, 1, 0);
    idle(1, 0, 0, 0);
    cyc(1, 0, 1, I_SW, 32'h208, 0, 1, 1);
    idle(2, 0, 1, 1);
    cyc(1, 0, 0, 32'd0, 32'd0, 0, 1, 0);
    cyc(1, 0, 1, I_LW, 32'h20C, 0, 0, 1);
    cyc(1, 0, 0, 32'd0, 32'd0, 0, 1, 0);

    // Rollback with five queued and a concurrent fetch.
    for (int i = 0; i < 5; i++) cyc(1, 0, 1, I_ADD, 32'h300 + 4*i, 1, 0, 0);
    cyc(1, 1, 1, I_ADD, 32'h314, 0, 0, 0);
    idle(2, 0, 0, 0);

    // Steady push+pop across the pointer wrap.
    for (int i = 0; i < 41; i++) cyc(1, 0, i < 40, I_ADDI, 32'(4*i), 0, 0, 0);

    // rdy low mid-stream with fetch still presenting.
    pc_run = 32'h400;
    for (int i = 0; i < 16; i++) begin
      if (i >= 6 && i < 9) cyc(0, 0, 1, I_ADDI, pc_run, 0, 0, 0);
      else begin
        cyc(1, 0, 1, I_ADDI, pc_run, (i % 4) == 1, 0, 0);
        pc_run = pc_run + 4;
      end
    end
    idle(18, 0, 0, 0);

    // Randomized mix of classes, flags, rdy and rollback.
    pc_run = 32'h1000;
    for (int i = 0; i < 400; i++) begin
      r = $urandom;
      case ($urandom_range(0, 2))
        0: opc = 7'h03;
        1: opc = 7'h23;
        default: opc = 7'h33;
      endcase
      cyc($urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0,
          ($urandom_range(0, 2) != 0) && (sb.size() < 15),
          {r[31:7], opc}, pc_run,
          $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
      pc_run = pc_run + 4;
    end
    idle(20, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
